// File: rtl/mdu_seq.sv
// Sequential 32-bit multiply/divide unit with HI/LO result registers.
// Define MDU_DIV_EN to build the divider; otherwise DIV/DIVU complete at once without touching HI/LO.
module mdu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] DATA_IN1,
    input  logic [31:0] DATA_IN2,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] b_q, b_d;
    logic [63:0] p_q, p_d;
    logic        neg_lo_q, neg_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div0_q, div0_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        accept_s, a_neg_s, b_neg_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s, step_next_s, prod_fix_s;
    logic [31:0] fix_hi_s, fix_lo_s;

    assign accept_s   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign a_neg_s    = ~op[0] & DATA_IN1[31];
    assign b_neg_s    = ~op[0] & DATA_IN2[31];
    assign a_mag_s    = a_neg_s ? (32'd0 - DATA_IN1) : DATA_IN1;
    assign b_mag_s    = b_neg_s ? (32'd0 - DATA_IN2) : DATA_IN2;
    // Shift-add: multiplier sits in the low half and shifts out as product bits shift in.
    assign mul_sum_s  = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? b_q : 32'd0)};
    assign mul_next_s = {mul_sum_s, p_q[31:1]};
    assign prod_fix_s = neg_lo_q ? (64'd0 - p_q) : p_q;

`ifdef MDU_DIV_EN
    logic        is_div_q, is_div_d;
    logic        neg_hi_q, neg_hi_d;
    logic [32:0] div_rsh_s;
    logic [33:0] div_diff_s;
    logic [63:0] div_next_s;

    // Restoring step: {remainder, dividend/quotient} shifts left, subtract is kept when non-negative.
    assign div_rsh_s   = {p_q[63:32], p_q[31]};
    assign div_diff_s  = {1'b0, div_rsh_s} - {2'b00, b_q};
    assign div_next_s  = div_diff_s[33] ? {div_rsh_s[31:0], p_q[30:0], 1'b0}
                                        : {div_diff_s[31:0], p_q[30:0], 1'b1};
    assign step_next_s = is_div_q ? div_next_s : mul_next_s;

    // Divide-only flags captured at accept.
    always_comb begin
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        if (accept_s && start) begin
            is_div_d = op[1];
            neg_hi_d = a_neg_s;
        end else begin
            is_div_d = is_div_q;
            neg_hi_d = neg_hi_q;
        end
    end

    // Sign correction: quotient and remainder are corrected independently.
    always_comb begin
        if (is_div_q) begin
            fix_lo_s = neg_lo_q ? (32'd0 - p_q[31:0])  : p_q[31:0];
            fix_hi_s = neg_hi_q ? (32'd0 - p_q[63:32]) : p_q[63:32];
        end else begin
            fix_lo_s = prod_fix_s[31:0];
            fix_hi_s = prod_fix_s[63:32];
        end
    end

    // Divide flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
        end
    end
`else
    assign step_next_s = mul_next_s;
    assign fix_lo_s    = prod_fix_s[31:0];
    assign fix_hi_s    = prod_fix_s[63:32];
`endif

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        p_d      = p_q;
        neg_lo_d = neg_lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (op[1]) begin
`ifdef MDU_DIV_EN
                        if (DATA_IN2 == 32'd0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            div0_d  = 1'b1;
                            hi_d    = DATA_IN1;
                            lo_d    = 32'hFFFF_FFFF;
                        end else begin
                            state_d  = S_CALC;
                            cnt_d    = 5'd0;
                            b_d      = b_mag_s;
                            p_d      = {32'd0, a_mag_s};
                            neg_lo_d = a_neg_s ^ b_neg_s;
                        end
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d  = S_CALC;
                        cnt_d    = 5'd0;
                        b_d      = a_mag_s;
                        p_d      = {32'd0, b_mag_s};
                        neg_lo_d = a_neg_s ^ b_neg_s;
                    end
                end else begin
                    state_d = S_IDLE;
                    hi_d    = hi_we ? DATA_IN1 : hi_q;
                    lo_d    = lo_we ? DATA_IN1 : lo_q;
                end
            end
            S_CALC: begin
                p_d   = step_next_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                hi_d    = fix_hi_s;
                lo_d    = fix_lo_s;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            b_q      <= 32'd0;
            p_q      <= 64'd0;
            neg_lo_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            p_q      <= p_d;
            neg_lo_q <= neg_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: cycle-level reference model plus directed literal checks.
// Honours MDU_DIV_EN the same way as the design.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] din1 = 32'd0;
    logic [31:0] din2 = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    mdu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .DATA_IN1(din1), .DATA_IN2(din2), .hi_we(hi_we), .lo_we(lo_we),
        .busy(busy), .done(done), .div0(div0), .HI(hi), .LO(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Full result {HI,LO} from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00:   return sa * sb;
            2'b01:   return ua * ub;
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {(ua % ub) , 32'd0} | (ua / ub);
        endcase
    endfunction

    // Reference model: cycles of busy remaining, pending result, architectural HI/LO.
    int          m_left = 0;
    logic [63:0] m_res = 64'd0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic        m_done = 1'b0, m_div0 = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_hi = 32'd0; m_lo = 32'd0; m_done = 1'b0; m_div0 = 1'b0;
        end else begin
            m_done = 1'b0;
            m_div0 = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_res[63:32];
                    m_lo = m_res[31:0];
                    m_done = 1'b1;
                end
            end else if (start) begin
                if (!op[1]) begin
                    m_res = ref_result(op, din1, din2);
                    m_left = 33;
                end else begin
`ifdef MDU_DIV_EN
                    if (din2 == 32'd0) begin
                        m_hi = din1; m_lo = 32'hFFFF_FFFF; m_done = 1'b1; m_div0 = 1'b1;
                    end else begin
                        m_res = ref_result(op, din1, din2);
                        m_left = 33;
                    end
`else
                    m_done = 1'b1;
`endif
                end
            end else begin
                if (hi_we) m_hi = din1;
                if (lo_we) m_lo = din1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("cycle", {busy, done, div0, hi, lo},
              {(rst_n && m_left > 0), (rst_n && m_done), (rst_n && m_div0),
               (rst_n ? m_hi : 32'd0), (rst_n ? m_lo : 32'd0)});
    end

    // Issue one operation and time it; lat counts cycles from the accept edge to done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy, output logic d0);
        @(negedge clk); #1;
        start = 1'b1; op = o; din1 = a; din2 = b;
        @(posedge clk); #1;
        start = 1'b0; din1 = $urandom; din2 = $urandom;
        lat = 0; nbusy = 0; d0 = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                lat = k; d0 = div0;
                break;
            end
        end
        if (lat == 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    int   lat, nb;
    logic d0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_hi_lo_busy", {31'd0, busy, hi, lo}, 64'd0);
        #1 rst_n = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFE, 32'd3, lat, nb, d0);
        check("mult_lat", 64'(lat), 64'd34);
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nb, d0);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        check("multu_busy_cycles", 64'(nb), 64'd33);

`ifdef MDU_DIV_EN
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb, d0);
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_lat", 64'(lat), 64'd34);
        do_op(2'b11, 32'd100, 32'd7, lat, nb, d0);
        check("divu", {hi, lo}, {32'd2, 32'd14});
        do_op(2'b11, 32'd5, 32'd0, lat, nb, d0);
        check("div0_lat", 64'(lat), 64'd1);
        check("div0_flag", 64'(d0), 64'd1);
        check("div0_result", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb, d0);
        check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
`else
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nb, d0);
        check("div_off_lat", 64'(lat), 64'd1);
        check("div_off_div0", 64'(d0), 64'd0);
        check("div_off_hold", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(2'b11, 32'd5, 32'd0, lat, nb, d0);
        check("div_off_zero", {31'd0, d0, hi}, {32'd0, 32'hFFFF_FFFE});
`endif

        // Start+hi_we mid-CALC ignored, then reset at iteration 10.
        @(negedge clk); #1;
        start = 1'b1; op = 2'b00; din1 = 32'd3; din2 = 32'd5;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 start = 1'b1; hi_we = 1'b1; din1 = 32'hDEAD_BEEF;
        @(negedge clk); #1 start = 1'b0; hi_we = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_state", {31'd0, busy, hi, lo}, 64'd0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("abort_no_done", {63'd0, done}, 64'd0);
        end
        do_op(2'b00, 32'd6, 32'd7, lat, nb, d0);
        check("after_abort_mult", {hi, lo}, 64'd42);

        // Accept-cycle lo_we dropped, then dual write.
        @(negedge clk); #1;
        start = 1'b1; lo_we = 1'b1; op = 2'b01; din1 = 32'd9; din2 = 32'd4;
        @(posedge clk); #1 start = 1'b0; lo_we = 1'b0;
        repeat (36) @(negedge clk);
        check("lo_we_dropped", {hi, lo}, 64'd36);
        #1 hi_we = 1'b1; lo_we = 1'b1; din1 = 32'h1234_5678;
        @(negedge clk); #1 hi_we = 1'b0; lo_we = 1'b0; din1 = 32'd0;
        check("dual_write", {hi, lo}, 64'h1234_5678_1234_5678);
        repeat (3) @(negedge clk);
        check("hold", {hi, lo}, 64'h1234_5678_1234_5678);

        // Random traffic; the per-cycle comparison does the checking.
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk); #1;
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            din1  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            din2  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            hi_we = ($urandom_range(0, 3) == 0);
            lo_we = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #1 start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request a new operation; sampled only when accepting (IDLE or DONE state).
REQ-006 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
REQ-007 DATA_IN1  in  32  operand A (multiplicand or dividend), or HI/LO write data.
REQ-008 DATA_IN2  in  32  operand B (multiplier or divisor); sampled with start.
REQ-009 hi_we  in  1  write DATA_IN1 to HI (MTHI); honoured only when accepting.
REQ-010 lo_we  in  1  write DATA_IN1 to LO (MTLO); honoured only when accepting.
REQ-011 busy  out  1  high while an operation is in progress (CALC or FIX state).
REQ-012 done  out  1  one-cycle pulse when HI/LO hold a new result.
REQ-013 div0  out  1  high in the done cycle of a divide whose divisor is zero; low otherwise.
REQ-014 HI  out  32  registered HI result.
REQ-015 LO  out  32  registered LO result.

Function
REQ-016 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-017 Transitions: IDLE/DONE + start -> CALC; IDLE/DONE without start -> IDLE; CALC -> FIX after the 32nd iteration; FIX -> DONE.
REQ-018 In CALC, a 5-bit counter SHALL run from 0 to 31; each cycle performs one shift-add (multiply) or one restoring shift-subtract (divide) step on operand magnitudes.
REQ-019 Signed ops SHALL convert operands to magnitudes at accept; FIX SHALL apply sign correction and load HI/LO.
REQ-020 Latency: start sampled at edge T -> busy high T+1..T+33 -> done high and HI/LO valid at T+34.
REQ-021 MULT/MULTU: {HI,LO} SHALL equal the full 64-bit signed or unsigned product.
REQ-022 DIV/DIVU: LO SHALL be the quotient truncated toward zero and HI the remainder, carrying the sign of the dividend.
REQ-023 DIV with divisor 0: transition from accept straight to DONE; done and div0 high at T+1; HI = DATA_IN1; LO = 32'hFFFFFFFF.
REQ-024 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give LO = 32'h80000000 and HI = 0.
REQ-025 start while busy SHALL be ignored; there is no queueing.
REQ-026 hi_we/lo_we while busy SHALL be ignored; when accepting, both may be written in the same cycle.
REQ-027 start together with hi_we or lo_we: start wins and the writes are dropped.
REQ-028 HI/LO SHALL hold their values until overwritten by a result or a write.
REQ-029 Operands SHALL be captured at accept, so input changes during CALC have no effect.

Reset
REQ-030 While rst_n is low: state = IDLE, counter = 0, HI = LO = 0, busy = done = div0 = 0.
REQ-031 Reset asserted mid-operation SHALL abort it with no result; the first start after release SHALL be accepted normally.

Configuration
REQ-032 Macro MDU_DIV_EN defined: DIV/DIVU SHALL be implemented as specified.
REQ-033 MDU_DIV_EN undefined: the divider datapath SHALL be omitted; DIV/DIVU SHALL go accept -> DONE with done high at T+1, HI/LO unchanged and div0 = 0; multiply behaviour is unchanged.

Verification
REQ-034 MULT, A = 32'hFFFFFFFE (-2), B = 3 -> done at T+34, HI = 32'hFFFFFFFF, LO = 32'hFFFFFFFA.
REQ-035 MULTU, A = B = 32'hFFFFFFFF -> HI = 32'hFFFFFFFE, LO = 32'h00000001, busy high for exactly 33 cycles.
REQ-036 DIV, A = -7, B = 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF; DIVU, A = 100, B = 7 -> LO = 14, HI = 2.
REQ-037 DIVU, A = 5, B = 0 -> done and div0 at T+1, HI = 5, LO = 32'hFFFFFFFF.
REQ-038 start plus hi_we during CALC ignored; reset at iteration 10 -> busy = 0, HI = LO = 0, no done pulse, next MULT 6x7 gives LO = 42.
REQ-039 Accept-cycle start with lo_we -> LO write dropped; later hi_we = lo_we = 1 with DATA_IN1 = 32'h12345678 -> HI = LO = 32'h12345678.
